// File: rtl/fetch_decode_control_pkg.sv
// fetch_decode_control_pkg: shared state encoding, mux constants and strobe decode for the fetch/decode sequencer.
// Optional build macro FETCH_CTRL_INTERRUPT_EN enables the memory write strobe of the interrupt cycle.
package fetch_decode_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_EXEC, S_HALT, S_INT0, S_INT1, S_INT2
    } state_t;

    localparam logic [1:0]  SRC_PC     = 2'd0;
    localparam logic [1:0]  SRC_IR     = 2'd1;
    localparam logic [1:0]  SRC_MEM    = 2'd2;
    localparam logic [2:0]  OPC_REG_IO = 3'd7;
    localparam logic [15:0] HLT_WORD   = 16'h7001;

    typedef struct packed {
        logic       ar_ld;
        logic       ar_clr;
        logic [1:0] ar_src;
        logic       pc_inr;
        logic       pc_clr;
        logic       ir_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
    } ctl_t;

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_T0:   c.ar_ld = 1'b1;
            S_T1:   begin c.mem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_inr = 1'b1; end
            S_T2:   begin c.ar_ld = 1'b1; c.ar_src = SRC_IR; end
            S_T3:   begin c.mem_rd = 1'b1; c.ar_ld = 1'b1; c.ar_src = SRC_MEM; end
            S_HALT: c.halted = 1'b1;
            S_INT0: c.ar_clr = 1'b1;
`ifdef FETCH_CTRL_INTERRUPT_EN
            S_INT1: begin c.mem_wr = 1'b1; c.pc_clr = 1'b1; end
`else
            S_INT1: c.pc_clr = 1'b1;
`endif
            S_INT2: c.pc_inr = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_decode_control.sv
// fetch_decode_control: instruction-cycle sequencer (fetch, decode, indirect, execute handoff) for the accumulator CPU.
// Ports: CLK clock; CLR sync active-high reset; START run request; IR current instruction word;
//        EXEC_DONE execute finished; IRQ interrupt request (only with FETCH_CTRL_INTERRUPT_EN);
//        AR_LD/AR_CLR/AR_SRC AR controls; PC_INR/PC_CLR PC controls; IR_LD IR load;
//        MEM_RD/MEM_WR memory strobes; EXEC_START execute start pulse; OPCODE/I_FLAG latched fields;
//        SC sequence count; HALTED high in HALT.
// Optional build macro FETCH_CTRL_INTERRUPT_EN adds the IRQ input and the INT0-INT2 interrupt cycle.
module fetch_decode_control
    import fetch_decode_control_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 16,
    parameter int SC_W   = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic [WORD_W-1:0] IR,
    input  logic              EXEC_DONE,
`ifdef FETCH_CTRL_INTERRUPT_EN
    input  logic              IRQ,
`endif
    output logic              AR_LD,
    output logic              AR_CLR,
    output logic [1:0]        AR_SRC,
    output logic              PC_INR,
    output logic              PC_CLR,
    output logic              IR_LD,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic              EXEC_START,
    output logic [2:0]        OPCODE,
    output logic              I_FLAG,
    output logic [SC_W-1:0]   SC,
    output logic              HALTED
);

    state_t st, nxt;
    ctl_t   ctl;
    logic   go_int;

`ifdef FETCH_CTRL_INTERRUPT_EN
    assign go_int = IRQ;
`else
    assign go_int = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE, S_HALT: nxt = START ? S_T0 : st;
            S_T0:   nxt = S_T1;
            S_T1:   nxt = S_T2;
            S_T2:   nxt = (IR == WORD_W'(HLT_WORD)) ? S_HALT :
                          (IR[WORD_W-2:ADDR_W] != OPC_REG_IO && IR[WORD_W-1]) ? S_T3 : S_EXEC;
            S_T3:   nxt = S_EXEC;
            S_EXEC: nxt = EXEC_DONE ? (go_int ? S_INT0 : S_T0) : S_EXEC;
            S_INT0: nxt = S_INT1;
            S_INT1: nxt = S_INT2;
            S_INT2: nxt = S_T0;
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet still
    // line up with the state they belong to.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            st         <= S_IDLE;
            ctl        <= '0;
            EXEC_START <= 1'b0;
            OPCODE     <= '0;
            I_FLAG     <= 1'b0;
            SC         <= '0;
        end else begin
            st         <= nxt;
            ctl        <= decode(nxt);
            EXEC_START <= nxt == S_EXEC && st != S_EXEC;
            SC         <= (nxt inside {S_IDLE, S_T0, S_HALT}) ? '0 : (&SC ? SC : SC + SC_W'(1));
            if (st == S_T2) begin
                OPCODE <= IR[WORD_W-2:ADDR_W];
                I_FLAG <= IR[WORD_W-1];
            end
        end
    end

    assign AR_LD  = ctl.ar_ld;
    assign AR_CLR = ctl.ar_clr;
    assign AR_SRC = ctl.ar_src;
    assign PC_INR = ctl.pc_inr;
    assign PC_CLR = ctl.pc_clr;
    assign IR_LD  = ctl.ir_ld;
    assign MEM_RD = ctl.mem_rd;
    assign MEM_WR = ctl.mem_wr;
    assign HALTED = ctl.halted;

endmodule

// File: tb/tb_fetch_decode_control.sv
// tb_fetch_decode_control: scoreboard bench; the stimulus side queues the expected per-cycle outputs, a monitor compares.
module tb_fetch_decode_control;

    logic        clk = 1'b0;
    logic        clr, start, exec_done, irq;
    logic [15:0] ir;
    logic        ar_ld, ar_clr, pc_inr, pc_clr, ir_ld, mem_rd, mem_wr, exec_start, i_flag, halted;
    logic [1:0]  ar_src;
    logic [2:0]  opcode;
    logic [3:0]  sc;

    always #5 clk = ~clk;

    fetch_decode_control dut (
        .CLK(clk), .CLR(clr), .START(start), .IR(ir), .EXEC_DONE(exec_done),
`ifdef FETCH_CTRL_INTERRUPT_EN
        .IRQ(irq),
`endif
        .AR_LD(ar_ld), .AR_CLR(ar_clr), .AR_SRC(ar_src), .PC_INR(pc_inr), .PC_CLR(pc_clr),
        .IR_LD(ir_ld), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .EXEC_START(exec_start),
        .OPCODE(opcode), .I_FLAG(i_flag), .SC(sc), .HALTED(halted)
    );

    typedef struct packed {
        logic [9:0] strobes;
        logic [2:0] opcode;
        logic       i_flag;
        logic [3:0] sc;
        logic       halted;
    } obs_t;

    // strobe field order: ar_ld ar_clr ar_src[1:0] pc_inr pc_clr ir_ld mem_rd mem_wr exec_start
    localparam logic [9:0] NONE     = 10'b0000000000;
    localparam logic [9:0] AR_PC    = 10'b1000000000;
    localparam logic [9:0] AR_IR    = 10'b1001000000;
    localparam logic [9:0] FETCH    = 10'b0000101100;
    localparam logic [9:0] INDIRECT = 10'b1010000100;
    localparam logic [9:0] XSTART   = 10'b0000000001;
    localparam logic [9:0] ACLR     = 10'b0100000000;
    localparam logic [9:0] STORE    = 10'b0000010010;
    localparam logic [9:0] INC      = 10'b0000100000;

    obs_t        q[$];
    string       tq[$];
    int          checks = 0, failures = 0;
    int          m_sc;
    logic [2:0]  m_opc;
    logic        m_i;

    obs_t obs;
    assign obs = {ar_ld, ar_clr, ar_src, pc_inr, pc_clr, ir_ld, mem_rd, mem_wr, exec_start,
                  opcode, i_flag, sc, halted};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t  e;
            string t;
            e = q.pop_front();
            t = tq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", t, obs, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Queue the outputs expected after the next rising edge, then take that edge.
    task automatic cyc(input string tag, input logic [9:0] s, input bit sc_zero, input logic h);
        m_sc = sc_zero ? 0 : (m_sc < 15 ? m_sc + 1 : 15);
        q.push_back({s, m_opc, m_i, 4'(m_sc), h});
        tq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Entered with inputs set so the next edge goes to T0; leaves EXEC_DONE set so
    // the following edge returns to T0 (unless the instruction halted).
    task automatic run_instr(input logic [15:0] w, input int waits, input bit take_irq);
        ir = w;
        cyc("T0", AR_PC, 1, 0);
        start = 0; exec_done = 0; irq = 0;
        cyc("T1", FETCH, 0, 0);
        cyc("T2", AR_IR, 0, 0);
        m_opc = w[14:12];
        m_i   = w[15];
        if (w == 16'h7001) begin
            cyc("HALT", NONE, 1, 1);
            return;
        end
        if (w[15] && w[14:12] != 3'd7) cyc("T3", INDIRECT, 0, 0);
        cyc("EXEC0", XSTART, 0, 0);
        for (int k = 0; k < waits; k++) begin
            start = 1'($urandom);
            irq   = 1'($urandom);
            cyc("EXECW", NONE, 0, 0);
        end
        start = 0; exec_done = 1; irq = take_irq;
        if (take_irq) begin
            cyc("INT0", ACLR, 0, 0);
            exec_done = 0;
            irq = 1'($urandom);
            cyc("INT1", STORE, 0, 0);
            cyc("INT2", INC, 0, 0);
        end
    endtask

    initial begin
        clr = 1; start = 0; exec_done = 0; irq = 0; ir = 0;
        m_opc = 0; m_i = 0; m_sc = 0;
        cyc("RST0", NONE, 1, 0);
        cyc("RST1", NONE, 1, 0);
        clr = 0;
        cyc("IDLE", NONE, 1, 0);
        start = 1;
        run_instr(16'h9123, 0, 0);
        run_instr(16'h7800, 13, 0);
        run_instr(16'h7001, 0, 0);
        start = 0;
        cyc("HALT_HOLD", NONE, 1, 1);
        cyc("HALT_HOLD", NONE, 1, 1);
        start = 1;
        run_instr(16'h1234, 2, 0);
        ir = 16'h0456;
        cyc("T0", AR_PC, 1, 0);
        exec_done = 0;
        cyc("T1", FETCH, 0, 0);
        clr = 1;
        m_opc = 0; m_i = 0;
        cyc("CLR_T1", NONE, 1, 0);
        clr = 0;
        cyc("IDLE_AFTER_CLR", NONE, 1, 0);
        cyc("IDLE_AFTER_CLR", NONE, 1, 0);
        start = 1;
`ifdef FETCH_CTRL_INTERRUPT_EN
        run_instr(16'h2005, 1, 1);
        run_instr(16'h3000, 0, 0);
`endif
        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            int          waits;
            bit          ti;
            case ($urandom_range(0, 3))
                0:       w = 16'h7001;
                1:       w = {1'($urandom), 3'd7, 12'($urandom)};
                default: w = 16'($urandom);
            endcase
            waits = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 4);
`ifdef FETCH_CTRL_INTERRUPT_EN
            ti = 1'($urandom);
`else
            ti = 1'b0;
`endif
            start = 1;
            run_instr(w, waits, ti);
            if (w == 16'h7001) begin
                start = 0;
                for (int k = 0; k < $urandom_range(0, 2); k++) cyc("HALT_HOLD", NONE, 1, 1);
                start = 1;
            end
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
